parchk_serial: RTL and testbench
================================

// Module: parchk_serial
//
// PURPOSE
//   Receive-side counterpart of the 3-input odd-parity generator.
//   - Deserialises frames of DATA_W data bits (MSB first) plus one trailing parity bit.
//   - Checks odd parity: the data bits plus the parity bit must contain an odd number of 1s.
//   - Presents the word with a one-cycle done strobe and an error flag.
//   - Sits between a serial link and the word-level consumer.
//
// PARAMETERS
//   DATA_W   3   data bits per frame (>=2); total frame length is DATA_W+1 bits
//   CNT_W    8   width of saturating error counter (used only with PARCHK_ERRCNT_EN)
//
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   sof         in   1        start of frame; qualifies the first data bit; valid only with bit_valid=1
//   bit_valid   in   1        bit_in is valid this cycle
//   bit_in      in   1        serial data/parity bit
//   data_out    out  DATA_W   last received data word; held until the next frame_done
//   frame_done  out  1        one-cycle strobe: data_out and par_err are updated
//   par_err     out  1        1 = parity violation in the frame flagged by frame_done; held
//   frame_abort out  1        one-cycle strobe: a frame in progress was discarded by a new sof
//   err_cnt     out  CNT_W    saturating count of parity errors (PARCHK_ERRCNT_EN only)
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; data_out=0; frame_done=0; par_err=0;
//     frame_abort=0; err_cnt=0; shift register=0; bit counter=0.
//   - FSM:
//     - IDLE: waits for sof&bit_valid. On that cycle it shifts in the first data bit,
//       sets count=1 and goes to DATA. Bits received in IDLE without sof are ignored.
//     - DATA: each bit_valid shifts bit_in in at the LSB (so the MSB arrives first)
//       and increments count. When count reaches DATA_W it goes to PARITY.
//       Cycles with bit_valid=0 are stalls: no state change.
//     - PARITY: the next bit_valid captures the parity bit p.
//       - data_out <= shift register; par_err <= ~(^shift ^ p).
//       - frame_done=1 on the following cycle (registered, one-cycle latency after the parity bit).
//       - Returns to IDLE.
//   - The frame_done and frame_abort strobes are each high for exactly one cycle.
//   - A parity bit with sof=1 is treated as a parity bit; sof is ignored in PARITY.
//   - A new frame can start in the cycle right after the parity bit; back-to-back
//     frames need no idle gap.
//   - sof&bit_valid while in DATA:
//     - The partial frame is discarded and frame_abort pulses the next cycle.
//     - The sof bit becomes data bit 1 of a new frame (count=1, stay in DATA).
//     - data_out and par_err are unchanged.
//   - Asserting rst_n mid-frame discards the frame with no strobe.
//
// CONFIGURATION
//   - PARCHK_ERRCNT_EN defined: err_cnt increments on every frame_done with
//     par_err=1 and saturates at 2^CNT_W-1 (no wrap). It is cleared only by reset.
//   - PARCHK_ERRCNT_EN undefined: no counter logic is built and err_cnt is tied to 0.
//
// TESTING
//   1. DATA_W=3. Send 0,0,0 then p=1 -> frame_done one cycle later; data_out=3'b000; par_err=0.
//   2. Send 1,0,1 then p=0 -> data_out=3'b101; par_err=1.
//      With PARCHK_ERRCNT_EN, err_cnt goes 0->1.
//   3. Exhaustive: all 8 words, each with the correct and the inverted parity bit,
//      sent back-to-back -> par_err matches the truth table; 16 frame_done pulses.
//   4. Insert bit_valid=0 stalls of 0 to 5 cycles between bits of 3'b110/p=1
//      -> data_out=3'b110; par_err=0; frame_done exactly once.
//   5. After 2 data bits, assert sof with bit=0, then send 1,1 and p=1
//      -> frame_abort pulses once; data_out=3'b011; par_err=0.
//   6. Force 300 bad frames with CNT_W=8 -> err_cnt=255 (saturated).
//      Then pulse rst_n low mid-frame -> all outputs read 0; no frame_done.

Source files
------------

// File: rtl/parchk_serial.sv
// Serial odd-parity frame receiver: DATA_W data bits MSB first, then one parity bit.
// Optional saturating parity-error counter enabled by defining PARCHK_ERRCNT_EN.
module parchk_serial #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_done,
  output logic              par_err,
  output logic              frame_abort,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          shift_d = {shift_q[DATA_W-2:0], bit_in};
          cnt_d   = CW'(1);
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_valid) begin
          shift_d = {shift_q[DATA_W-2:0], bit_in};
          if (sof) begin
            // Restart: the sof bit is data bit 1 of the replacement frame.
            cnt_d   = CW'(1);
            abort_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == LAST) state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_valid) begin
          data_d  = shift_q;
          perr_d  = ~(^shift_q ^ bit_in);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out    = data_q;
  assign par_err     = perr_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

`ifdef PARCHK_ERRCNT_EN
  logic [CNT_W-1:0] errc_q, errc_d;

  // Updated on the same edge that raises frame_done, so both are visible together.
  always_comb begin
    errc_d = errc_q;
    if (done_d && perr_d && (errc_q != {CNT_W{1'b1}})) errc_d = errc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errc_q <= '0;
    else        errc_q <= errc_d;
  end

  assign err_cnt = errc_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parchk_serial.sv
// Self-checking bench for parchk_serial: vector table plus scoreboard of expected frames.
module tb_parchk_serial;

  localparam int DATA_W = 3;
  localparam int CNT_W  = 8;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sof = 1'b0;
  logic              bit_valid = 1'b0;
  logic              bit_in = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;
  logic              par_err;
  logic              frame_abort;
  logic [CNT_W-1:0]  err_cnt;

  parchk_serial #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .bit_valid(bit_valid), .bit_in(bit_in),
    .data_out(data_out), .frame_done(frame_done), .par_err(par_err),
    .frame_abort(frame_abort), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              p;
    logic              exp_err;
  } vec_t;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int abort_seen = 0;
  int exp_errcnt = 0;
  logic [DATA_W-1:0] last_data = '0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_cnt_out();
`ifdef PARCHK_ERRCNT_EN
    return exp_errcnt;
`else
    return 0;
`endif
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && frame_abort) abort_seen++;
    if (rst_n && frame_done) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.err && exp_errcnt < ERR_MAX) exp_errcnt++;
        last_data = e.d;
        check("data_out", data_out, e.d);
        check("par_err", par_err, e.err);
        check("err_cnt", err_cnt, exp_cnt_out());
      end
    end
  end

  task automatic drive_bit(input logic s, input logic b);
    sof = s; bit_valid = 1'b1; bit_in = b;
    @(posedge clk); #1;
    sof = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                            input logic exp_err, input int stall);
    exp_t e;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      drive_bit(i == DATA_W - 1, d[i]);
      idle(stall);
    end
    e.d = d; e.err = exp_err;
    sb.push_back(e);
    drive_bit(1'b0, p);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check(name, sb.size(), 0);
    @(negedge clk); @(posedge clk); #1;
  endtask

  vec_t vecs[18];

  initial begin
    int d0, a0;
    vecs[0] = '{d: 3'b000, p: 1'b1, exp_err: 1'b0};
    vecs[1] = '{d: 3'b101, p: 1'b0, exp_err: 1'b1};
    for (int i = 0; i < 8; i++) begin
      logic [DATA_W-1:0] w;
      w = DATA_W'(i);
      vecs[2 + 2*i] = '{d: w, p: ~(^w), exp_err: 1'b0};
      vecs[3 + 2*i] = '{d: w, p: ^w,    exp_err: 1'b1};
    end

    // Reset state
    #12;
    check("rst_data_out", data_out, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_par_err", par_err, 0);
    check("rst_frame_abort", frame_abort, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Bits without sof in IDLE are ignored
    drive_bit(1'b0, 1'b1); drive_bit(1'b0, 1'b0); drive_bit(1'b0, 1'b1); drive_bit(1'b0, 1'b1);
    idle(2);
    check("idle_ignore_done", done_seen, 0);

    // Directed first frames, then exhaustive back-to-back
    d0 = done_seen;
    for (int i = 0; i < 18; i++) send_frame(vecs[i].d, vecs[i].p, vecs[i].exp_err, 0);
    drain("table_drain");
    check("table_done_count", done_seen - d0, 18);

    // Stalls between bits
    for (int s = 0; s <= 5; s++) begin
      d0 = done_seen;
      send_frame(3'b110, 1'b1, 1'b0, s);
      drain("stall_drain");
      check("stall_done_once", done_seen - d0, 1);
    end

    // sof mid-frame restarts the frame
    d0 = done_seen; a0 = abort_seen;
    send_frame(3'b010, 1'b0, 1'b0, 0);
    drain("pre_abort_drain");
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    @(negedge clk);
    check("abort_strobe", frame_abort, 1);
    check("abort_data_held", data_out, 3'b010);
    @(posedge clk); #1;
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    begin
      exp_t e; e.d = 3'b011; e.err = 1'b0; sb.push_back(e);
    end
    drive_bit(1'b0, 1'b1);
    drain("abort_drain");
    check("abort_count", abort_seen - a0, 1);
    check("abort_done_count", done_seen - d0, 2);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) send_frame(3'b000, 1'b0, 1'b1, 0);
    drain("sat_drain");
    check("err_cnt_saturated", err_cnt, exp_cnt_out());
`ifdef PARCHK_ERRCNT_EN
    check("err_cnt_is_max", err_cnt, ERR_MAX);
`endif

    // Reset mid-frame
    d0 = done_seen;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    exp_errcnt = 0;
    last_data = '0;
    #1;
    check("mrst_data_out", data_out, 0);
    check("mrst_par_err", par_err, 0);
    check("mrst_err_cnt", err_cnt, 0);
    check("mrst_frame_done", frame_done, 0);
    idle(2);
    rst_n = 1'b1;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    idle(2);
    check("mrst_no_done", done_seen - d0, 0);
    send_frame(3'b110, 1'b1, 1'b0, 0);
    drain("post_rst_drain");
    check("post_rst_done", done_seen - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
